// File: rtl/microsequencer_pkg.sv
// Shared constants and encodings for the microsequencer, control ROM and instruction encoder.
// Holds the next-state select codes, the condition select codes and the fixed control states.
package microsequencer_pkg;

   localparam int STATE_W = 7;
   localparam int WCNT_W  = 8;

   localparam logic [STATE_W-1:0] RESET_STATE_C   = 7'd0;
   localparam logic [STATE_W-1:0] FETCH_STATE_C   = 7'd1;
   localparam logic [STATE_W-1:0] TIMEOUT_STATE_C = 7'd127;

   typedef enum logic [2:0] {
      NS_DISPATCH = 3'd0,
      NS_INCR     = 3'd1,
      NS_JUMP     = 3'd2,
      NS_CJUMP    = 3'd3,
      NS_WAIT_MOC = 3'd4,
      NS_FETCH    = 3'd5,
      NS_RSVD6    = 3'd6,
      NS_RSVD7    = 3'd7
   } nsel_e;

   typedef enum logic [1:0] {
      CS_MOC  = 2'd0,
      CS_COND = 2'd1,
      CS_ONE  = 2'd2,
      CS_ZERO = 2'd3
   } csel_e;

   // Wraps from 127 back to 0 through natural 7-bit overflow.
   function automatic logic [STATE_W-1:0] incr_state(input logic [STATE_W-1:0] s);
      return s + 7'd1;
   endfunction

endpackage

// File: rtl/microsequencer_next_state_mux.sv
// Combinational next-state selection: incrementer, condition mux and source select.
// Also reports which side effects (dispatch, timeout, counter advance) the choice implies.
module next_state_mux
   import microsequencer_pkg::*;
#(
   parameter logic [STATE_W-1:0] FETCH_STATE   = FETCH_STATE_C,
   parameter logic [STATE_W-1:0] TIMEOUT_STATE = TIMEOUT_STATE_C
) (
   input  logic [STATE_W-1:0] state_i,
   input  logic [2:0]         nsel_i,
   input  logic [1:0]         csel_i,
   input  logic               inv_i,
   input  logic               cond_true_i,
   input  logic               moc_i,
   input  logic [STATE_W-1:0] encoder_i,
   input  logic [STATE_W-1:0] cr_addr_i,
   input  logic               at_limit_i,
   output logic [STATE_W-1:0] next_state_o,
   output logic               dispatch_o,
   output logic               timeout_o,
   output logic               wait_inc_o
);

   logic [STATE_W-1:0] state_inc;
   logic               cond_sel;
   logic               cond_c;

   assign state_inc = incr_state(state_i);

   always_comb begin
      cond_sel = 1'b0;
      case (csel_e'(csel_i))
         CS_MOC:  cond_sel = moc_i;
         CS_COND: cond_sel = cond_true_i;
         CS_ONE:  cond_sel = 1'b1;
         CS_ZERO: cond_sel = 1'b0;
         default: cond_sel = 1'b0;
      endcase
   end

   assign cond_c = cond_sel ^ inv_i;

   always_comb begin
      next_state_o = FETCH_STATE;
      dispatch_o   = 1'b0;
      timeout_o    = 1'b0;
      wait_inc_o   = 1'b0;
      case (nsel_e'(nsel_i))
         NS_DISPATCH: begin
            if (cond_true_i) begin
               next_state_o = encoder_i;
               dispatch_o   = 1'b1;
            end else begin
               next_state_o = FETCH_STATE;
            end
         end
         NS_INCR:  next_state_o = state_inc;
         NS_JUMP:  next_state_o = cr_addr_i;
         NS_CJUMP: next_state_o = cond_c ? cr_addr_i : state_inc;
         NS_WAIT_MOC: begin
            // moc takes priority over the watchdog when both land on the same edge.
            if (moc_i) begin
               next_state_o = state_inc;
            end else if (at_limit_i) begin
               next_state_o = TIMEOUT_STATE;
               timeout_o    = 1'b1;
            end else begin
               next_state_o = state_i;
               wait_inc_o   = 1'b1;
            end
         end
         NS_FETCH: next_state_o = FETCH_STATE;
         default:  next_state_o = FETCH_STATE;
      endcase
   end

endmodule

// File: rtl/microsequencer.sv
// Control-state register for the microprogrammed control unit, with the memory-wait
// watchdog counter and the registered dispatch / bus-error pulses.
module microsequencer
   import microsequencer_pkg::*;
#(
   parameter logic [STATE_W-1:0] RESET_STATE   = RESET_STATE_C,
   parameter logic [STATE_W-1:0] FETCH_STATE   = FETCH_STATE_C,
   parameter logic [STATE_W-1:0] TIMEOUT_STATE = TIMEOUT_STATE_C,
   parameter int                 WAIT_LIMIT    = 16
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               halt,
   input  logic [STATE_W-1:0] encoder_IN,
   input  logic               cond_true,
   input  logic               moc,
   input  logic [2:0]         nsel,
   input  logic [1:0]         csel,
   input  logic               inv,
   input  logic [STATE_W-1:0] cr_addr,
   output logic [STATE_W-1:0] state,
   output logic               dispatch,
   output logic               bus_err,
   output logic [WCNT_W-1:0]  wait_cnt
);

   localparam logic [WCNT_W-1:0] LIMIT_M1 = WCNT_W'(WAIT_LIMIT - 1);

   logic [STATE_W-1:0] state_q, state_d;
   logic [WCNT_W-1:0]  wait_cnt_q, wait_cnt_d;
   logic               dispatch_q, dispatch_d;
   logic               bus_err_q, bus_err_d;

   logic [STATE_W-1:0] mux_next;
   logic               mux_dispatch;
   logic               mux_timeout;
   logic               mux_wait_inc;
   logic               at_limit;

   assign at_limit = (wait_cnt_q == LIMIT_M1);

   next_state_mux #(
      .FETCH_STATE   (FETCH_STATE),
      .TIMEOUT_STATE (TIMEOUT_STATE)
   ) u_next_state_mux (
      .state_i      (state_q),
      .nsel_i       (nsel),
      .csel_i       (csel),
      .inv_i        (inv),
      .cond_true_i  (cond_true),
      .moc_i        (moc),
      .encoder_i    (encoder_IN),
      .cr_addr_i    (cr_addr),
      .at_limit_i   (at_limit),
      .next_state_o (mux_next),
      .dispatch_o   (mux_dispatch),
      .timeout_o    (mux_timeout),
      .wait_inc_o   (mux_wait_inc)
   );

   // halt freezes state and counter; the pulses drop so nothing is reported twice.
   always_comb begin
      state_d    = state_q;
      wait_cnt_d = wait_cnt_q;
      dispatch_d = 1'b0;
      bus_err_d  = 1'b0;
      if (!halt) begin
         state_d    = mux_next;
         wait_cnt_d = mux_wait_inc ? (wait_cnt_q + 8'd1) : '0;
         dispatch_d = mux_dispatch;
         bus_err_d  = mux_timeout;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= RESET_STATE;
         wait_cnt_q <= '0;
         dispatch_q <= 1'b0;
         bus_err_q  <= 1'b0;
      end else begin
         state_q    <= state_d;
         wait_cnt_q <= wait_cnt_d;
         dispatch_q <= dispatch_d;
         bus_err_q  <= bus_err_d;
      end
   end

   assign state    = state_q;
   assign dispatch = dispatch_q;
   assign bus_err  = bus_err_q;
   assign wait_cnt = wait_cnt_q;

endmodule

// File: tb/tb_microsequencer.sv
// Self-checking bench for microsequencer: vector table plus directed multi-cycle sequences,
// with expected outputs queued at drive time and compared after each clock edge.
module tb_microsequencer;

   logic       clk;
   logic       rst_n;
   logic       halt;
   logic [6:0] encoder_IN;
   logic       cond_true;
   logic       moc;
   logic [2:0] nsel;
   logic [1:0] csel;
   logic       inv;
   logic [6:0] cr_addr;
   logic [6:0] state;
   logic       dispatch;
   logic       bus_err;
   logic [7:0] wait_cnt;

   int n_tests = 0;
   int n_fail  = 0;

   // Expected word: {state[6:0], dispatch, bus_err, wait_cnt[7:0]}
   logic [16:0] exp_q[$];

   typedef struct {
      logic [2:0] nsel;
      logic [1:0] csel;
      logic       inv;
      logic       cond;
      logic       moc;
      logic [6:0] enc;
      logic [6:0] cr;
      logic       halt;
      logic [6:0] e_state;
      logic       e_disp;
      logic       e_berr;
      logic [7:0] e_wait;
   } vec_t;

   vec_t vecs[$];

   microsequencer #(.WAIT_LIMIT(16)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .halt       (halt),
      .encoder_IN (encoder_IN),
      .cond_true  (cond_true),
      .moc        (moc),
      .nsel       (nsel),
      .csel       (csel),
      .inv        (inv),
      .cr_addr    (cr_addr),
      .state      (state),
      .dispatch   (dispatch),
      .bus_err    (bus_err),
      .wait_cnt   (wait_cnt)
   );

   // clock / reset
   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string name, input logic [16:0] act, input logic [16:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got state=%0d disp=%0b berr=%0b wait=%0d, want state=%0d disp=%0b berr=%0b wait=%0d",
                  name, act[16:10], act[9], act[8], act[7:0], exp[16:10], exp[9], exp[8], exp[7:0]);
      end
   endtask

   function automatic logic [16:0] pack_exp(input logic [6:0] s, input logic d, input logic b,
                                            input logic [7:0] w);
      return {s, d, b, w};
   endfunction

   // driver: apply one cycle of inputs, queue the expectation, compare after the edge
   task automatic step(input string name, input logic [2:0] ns, input logic [1:0] cs,
                       input logic iv, input logic ct, input logic mc, input logic [6:0] enc,
                       input logic [6:0] cr, input logic hl, input logic [6:0] es,
                       input logic ed, input logic eb, input logic [7:0] ew);
      logic [16:0] e;
      nsel = ns; csel = cs; inv = iv; cond_true = ct; moc = mc;
      encoder_IN = enc; cr_addr = cr; halt = hl;
      exp_q.push_back(pack_exp(es, ed, eb, ew));
      @(posedge clk);
      #1;
      e = exp_q.pop_front();
      check(name, {state, dispatch, bus_err, wait_cnt}, e);
   endtask

   task automatic add(input logic [2:0] ns, input logic [1:0] cs, input logic iv,
                      input logic ct, input logic mc, input logic [6:0] enc, input logic [6:0] cr,
                      input logic hl, input logic [6:0] es, input logic ed, input logic eb,
                      input logic [7:0] ew);
      vec_t v;
      v.nsel = ns; v.csel = cs; v.inv = iv; v.cond = ct; v.moc = mc; v.enc = enc;
      v.cr = cr; v.halt = hl; v.e_state = es; v.e_disp = ed; v.e_berr = eb; v.e_wait = ew;
      vecs.push_back(v);
   endtask

   task automatic jump_to(input logic [6:0] s);
      step("jump_setup", 3'd2, 2'd0, 1'b0, 1'b0, 1'b0, 7'd0, s, 1'b0, s, 1'b0, 1'b0, 8'd0);
   endtask

   task automatic wait_cycle(input string name, input logic mc, input logic [6:0] es,
                             input logic eb, input logic [7:0] ew);
      step(name, 3'd4, 2'd0, 1'b0, 1'b0, mc, 7'd0, 7'd0, 1'b0, es, 1'b0, eb, ew);
   endtask

   initial begin
      //    nsel  csel  inv  cond moc  enc    cr     halt  state  d     b     wait
      add(3'd5, 2'd0, 1'b0, 1'b0, 1'b0, 7'd0,  7'd0,  1'b0, 7'd1,  1'b0, 1'b0, 8'd0);
      add(3'd0, 2'd0, 1'b0, 1'b1, 1'b0, 7'd43, 7'd0,  1'b0, 7'd43, 1'b1, 1'b0, 8'd0);
      add(3'd1, 2'd0, 1'b0, 1'b0, 1'b0, 7'd0,  7'd0,  1'b0, 7'd44, 1'b0, 1'b0, 8'd0);
      add(3'd5, 2'd0, 1'b0, 1'b0, 1'b0, 7'd0,  7'd0,  1'b0, 7'd1,  1'b0, 1'b0, 8'd0);
      add(3'd0, 2'd0, 1'b0, 1'b0, 1'b0, 7'd43, 7'd0,  1'b0, 7'd1,  1'b0, 1'b0, 8'd0);
      add(3'd2, 2'd0, 1'b0, 1'b0, 1'b0, 7'd0,  7'd10, 1'b0, 7'd10, 1'b0, 1'b0, 8'd0);
      add(3'd3, 2'd1, 1'b0, 1'b1, 1'b0, 7'd0,  7'd90, 1'b0, 7'd90, 1'b0, 1'b0, 8'd0);
      add(3'd2, 2'd0, 1'b0, 1'b0, 1'b0, 7'd0,  7'd10, 1'b0, 7'd10, 1'b0, 1'b0, 8'd0);
      add(3'd3, 2'd1, 1'b1, 1'b1, 1'b0, 7'd0,  7'd90, 1'b0, 7'd11, 1'b0, 1'b0, 8'd0);
      add(3'd2, 2'd0, 1'b0, 1'b0, 1'b0, 7'd0,  7'd10, 1'b0, 7'd10, 1'b0, 1'b0, 8'd0);
      add(3'd3, 2'd3, 1'b0, 1'b1, 1'b0, 7'd0,  7'd90, 1'b0, 7'd11, 1'b0, 1'b0, 8'd0);
      add(3'd3, 2'd2, 1'b0, 1'b0, 1'b0, 7'd0,  7'd90, 1'b0, 7'd90, 1'b0, 1'b0, 8'd0);
      add(3'd3, 2'd0, 1'b1, 1'b0, 1'b0, 7'd0,  7'd70, 1'b0, 7'd70, 1'b0, 1'b0, 8'd0);
      add(3'd3, 2'd0, 1'b0, 1'b0, 1'b1, 7'd0,  7'd33, 1'b0, 7'd33, 1'b0, 1'b0, 8'd0);
      add(3'd2, 2'd0, 1'b0, 1'b0, 1'b0, 7'd0,  7'd127,1'b0, 7'd127,1'b0, 1'b0, 8'd0);
      add(3'd1, 2'd0, 1'b0, 1'b0, 1'b0, 7'd0,  7'd0,  1'b0, 7'd0,  1'b0, 1'b0, 8'd0);
      add(3'd6, 2'd0, 1'b0, 1'b0, 1'b0, 7'd0,  7'd55, 1'b0, 7'd1,  1'b0, 1'b0, 8'd0);
      add(3'd2, 2'd0, 1'b0, 1'b0, 1'b0, 7'd0,  7'd5,  1'b0, 7'd5,  1'b0, 1'b0, 8'd0);
      add(3'd7, 2'd0, 1'b0, 1'b0, 1'b0, 7'd0,  7'd55, 1'b0, 7'd1,  1'b0, 1'b0, 8'd0);
      add(3'd0, 2'd0, 1'b0, 1'b1, 1'b0, 7'd0,  7'd0,  1'b0, 7'd0,  1'b1, 1'b0, 8'd0);
      add(3'd2, 2'd0, 1'b0, 1'b0, 1'b0, 7'd0,  7'd20, 1'b0, 7'd20, 1'b0, 1'b0, 8'd0);
      add(3'd4, 2'd0, 1'b0, 1'b0, 1'b0, 7'd0,  7'd0,  1'b0, 7'd20, 1'b0, 1'b0, 8'd1);
      add(3'd4, 2'd0, 1'b0, 1'b0, 1'b0, 7'd0,  7'd0,  1'b0, 7'd20, 1'b0, 1'b0, 8'd2);
      add(3'd4, 2'd0, 1'b0, 1'b0, 1'b0, 7'd0,  7'd0,  1'b0, 7'd20, 1'b0, 1'b0, 8'd3);
      add(3'd4, 2'd0, 1'b0, 1'b0, 1'b1, 7'd0,  7'd0,  1'b0, 7'd21, 1'b0, 1'b0, 8'd0);

      rst_n = 1'b1; halt = 1'b0; encoder_IN = '0; cond_true = 1'b0; moc = 1'b0;
      nsel = 3'd5; csel = 2'd0; inv = 1'b0; cr_addr = '0;

      // async reset asserted mid-cycle, observed before any edge
      #3 rst_n = 1'b0;
      #1 check("reset_async", {state, dispatch, bus_err, wait_cnt}, 17'd0);
      @(posedge clk); #1;
      check("reset_hold", {state, dispatch, bus_err, wait_cnt}, 17'd0);
      @(negedge clk) rst_n = 1'b1;

      foreach (vecs[i]) begin
         step($sformatf("vec%0d", i), vecs[i].nsel, vecs[i].csel, vecs[i].inv, vecs[i].cond,
              vecs[i].moc, vecs[i].enc, vecs[i].cr, vecs[i].halt, vecs[i].e_state,
              vecs[i].e_disp, vecs[i].e_berr, vecs[i].e_wait);
      end

      // timeout after WAIT_LIMIT edges, one-cycle bus_err pulse
      jump_to(7'd50);
      for (int i = 1; i <= 15; i++) wait_cycle($sformatf("to_cnt%0d", i), 1'b0, 7'd50, 1'b0, 8'(i));
      wait_cycle("to_fire", 1'b0, 7'd127, 1'b1, 8'd0);
      step("to_wrap", 3'd1, 2'd0, 1'b0, 1'b0, 1'b0, 7'd0, 7'd0, 1'b0, 7'd0, 1'b0, 1'b0, 8'd0);

      // moc arriving on the limit edge wins over the watchdog
      jump_to(7'd60);
      for (int i = 1; i <= 15; i++) wait_cycle($sformatf("mw_cnt%0d", i), 1'b0, 7'd60, 1'b0, 8'(i));
      wait_cycle("mw_moc_wins", 1'b1, 7'd61, 1'b0, 8'd0);

      // halt freezes state and counter during WAIT_MOC
      jump_to(7'd30);
      wait_cycle("hw_cnt1", 1'b0, 7'd30, 1'b0, 8'd1);
      wait_cycle("hw_cnt2", 1'b0, 7'd30, 1'b0, 8'd2);
      for (int i = 0; i < 5; i++)
         step($sformatf("hw_halt%0d", i), 3'd4, 2'd0, 1'b0, 1'b0, i[0], 7'd0, 7'd0, 1'b1,
              7'd30, 1'b0, 1'b0, 8'd2);
      wait_cycle("hw_cnt3", 1'b0, 7'd30, 1'b0, 8'd3);
      step("hw_leave", 3'd2, 2'd0, 1'b0, 1'b0, 1'b0, 7'd0, 7'd5, 1'b0, 7'd5, 1'b0, 1'b0, 8'd0);

      // halt suppresses a dispatch
      step("hd_fetch", 3'd5, 2'd0, 1'b0, 1'b0, 1'b0, 7'd0, 7'd0, 1'b0, 7'd1, 1'b0, 1'b0, 8'd0);
      step("hd_halted", 3'd0, 2'd0, 1'b0, 1'b1, 1'b0, 7'd43, 7'd0, 1'b1, 7'd1, 1'b0, 1'b0, 8'd0);
      step("hd_release", 3'd0, 2'd0, 1'b0, 1'b1, 1'b0, 7'd43, 7'd0, 1'b0, 7'd43, 1'b1, 1'b0, 8'd0);

      // reset mid-wait near the limit aborts with no bus_err
      jump_to(7'd70);
      for (int i = 1; i <= 14; i++) wait_cycle($sformatf("rw_cnt%0d", i), 1'b0, 7'd70, 1'b0, 8'(i));
      #3 rst_n = 1'b0;
      #1 check("rw_async", {state, dispatch, bus_err, wait_cnt}, 17'd0);
      @(posedge clk); #1;
      check("rw_no_berr", {state, dispatch, bus_err, wait_cnt}, 17'd0);
      @(negedge clk) rst_n = 1'b1;
      step("rw_restart", 3'd5, 2'd0, 1'b0, 1'b0, 1'b0, 7'd0, 7'd0, 1'b0, 7'd1, 1'b0, 1'b0, 8'd0);

      // random CJUMP against a small model
      for (int i = 0; i < 20; i++) begin
         logic [6:0] s0, tgt, es;
         logic [1:0] cs;
         logic       iv, ct, mc, c;
         s0 = 7'($urandom_range(0, 127));
         tgt = 7'($urandom_range(0, 127));
         cs = 2'($urandom_range(0, 3));
         iv = 1'($urandom_range(0, 1));
         ct = 1'($urandom_range(0, 1));
         mc = 1'($urandom_range(0, 1));
         jump_to(s0);
         case (cs)
            2'd0: c = mc;
            2'd1: c = ct;
            2'd2: c = 1'b1;
            default: c = 1'b0;
         endcase
         c = c ^ iv;
         es = c ? tgt : 7'(s0 + 7'd1);
         step($sformatf("rnd_cj%0d", i), 3'd3, cs, iv, ct, mc, 7'd0, tgt, 1'b0, es, 1'b0, 1'b0, 8'd0);
      end

      if (exp_q.size() != 0) begin
         n_tests++;
         n_fail++;
         $display("FAIL scoreboard_drain: %0d left, want 0", exp_q.size());
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
